// File: rtl/cpu_ex.sv
// cpu_ex: MIPS execute stage with ALU and EX/MEM pipeline register.
// Define CPU_EX_MULDIV_EN to build the iterative 32-cycle multiply/divide unit and HI/LO.
`ifndef CON_MSB
`define CON_MSB 15
`endif
`ifndef CON_LSB
`define CON_LSB 0
`endif

module cpu_ex (
  input  logic                      clk,
  input  logic                      clr_n,
  input  logic                      in_valid,
  input  logic [31:0]               current_pc,
  input  logic [31:0]               ins,
  input  logic [`CON_MSB:`CON_LSB]  controls,
  input  logic [4:0]                alu_op,
  input  logic [31:0]               reg_read1_data,
  input  logic [31:0]               reg_read2_data,
  input  logic [31:0]               imm_ext,
  input  logic                      alu_src_imm,
  output logic                      stall,
  output logic [31:0]               ex_current_pc,
  output logic [31:0]               ex_ins,
  output logic [`CON_MSB:`CON_LSB]  ex_controls,
  output logic [31:0]               ex_reg_read2_data,
  output logic [31:0]               ex_alu_result
);
  logic [31:0] op_a, op_b, alu_res;
  logic [4:0]  shamt;

  assign op_a  = reg_read1_data;
  assign op_b  = alu_src_imm ? imm_ext : reg_read2_data;
  assign shamt = ins[10:6];

`ifdef CPU_EX_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] hi, lo, mag_b;
  logic [63:0] acc, acc_next, prod_fix;
  logic        op_div, neg_q, neg_r, div_zero;
  logic [32:0] sum, r_sh;
  logic [31:0] r_sub, quo_fix, rem_fix, mag_a_in, mag_b_in;
  logic        is_muldiv, sgn_in;

  assign is_muldiv = (alu_op >= 5'd12) && (alu_op <= 5'd15);
  assign sgn_in    = ~alu_op[0];
  assign mag_a_in  = (sgn_in && op_a[31]) ? -op_a : op_a;
  assign mag_b_in  = (sgn_in && op_b[31]) ? -op_b : op_b;
  assign stall     = clr_n & (((state == S_IDLE) & in_valid & is_muldiv) | (state == S_BUSY));

  // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
  always_comb begin
    sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_b} : 33'd0);
    r_sh  = {acc[63:32], acc[31]};
    r_sub = r_sh[31:0] - mag_b;
    if (op_div) begin
      if (r_sh >= {1'b0, mag_b}) acc_next = {r_sub, acc[30:0], 1'b1};
      else                       acc_next = {r_sh[31:0], acc[30:0], 1'b0};
    end else begin
      acc_next = {sum, acc[31:1]};
    end
    prod_fix = neg_q ? -acc_next : acc_next;
    // divide-by-zero keeps the all-ones quotient regardless of operand signs
    quo_fix  = (neg_q && !div_zero) ? -acc_next[31:0] : acc_next[31:0];
    rem_fix  = neg_r ? -acc_next[63:32] : acc_next[63:32];
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state    <= S_IDLE;
      cnt      <= 5'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      acc      <= 64'd0;
      mag_b    <= 32'd0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && is_muldiv) begin
            state    <= S_BUSY;
            cnt      <= 5'd0;
            acc      <= {32'd0, mag_a_in};
            mag_b    <= mag_b_in;
            op_div   <= alu_op[1];
            neg_q    <= sgn_in & (op_a[31] ^ op_b[31]);
            neg_r    <= sgn_in & op_a[31];
            div_zero <= (mag_b_in == 32'd0);
          end else if (in_valid && alu_op == 5'd18) begin
            hi <= op_a;
          end else if (in_valid && alu_op == 5'd19) begin
            lo <= op_a;
          end
        end
        S_BUSY: begin
          acc <= acc_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= S_DONE;
            if (op_div) {hi, lo} <= {rem_fix, quo_fix};
            else        {hi, lo} <= prod_fix;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    alu_res = 32'd0;
    case (alu_op)
      5'd0:  alu_res = op_a + op_b;
      5'd1:  alu_res = op_a - op_b;
      5'd2:  alu_res = op_a & op_b;
      5'd3:  alu_res = op_a | op_b;
      5'd4:  alu_res = op_a ^ op_b;
      5'd5:  alu_res = ~(op_a | op_b);
      5'd6:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      5'd7:  alu_res = {31'd0, op_a < op_b};
      5'd8:  alu_res = op_b << shamt;
      5'd9:  alu_res = op_b >> shamt;
      5'd10: alu_res = $signed(op_b) >>> shamt;
      5'd11: alu_res = {op_b[15:0], 16'h0};
`ifdef CPU_EX_MULDIV_EN
      5'd16: alu_res = hi;
      5'd17: alu_res = lo;
`endif
      default: alu_res = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n || stall || !in_valid) begin
      ex_current_pc     <= 32'd0;
      ex_ins            <= 32'd0;
      ex_controls       <= '0;
      ex_reg_read2_data <= 32'd0;
      ex_alu_result     <= 32'd0;
    end else begin
      ex_current_pc     <= current_pc;
      ex_ins            <= ins;
      ex_controls       <= controls;
      ex_reg_read2_data <= reg_read2_data;
      ex_alu_result     <= alu_res;
    end
  end
endmodule

// File: tb/tb_cpu_ex.sv
// Directed bench for cpu_ex: ALU ops, bubbles, reset, and mul/div timing when CPU_EX_MULDIV_EN is set.
`ifndef CON_MSB
`define CON_MSB 15
`endif
`ifndef CON_LSB
`define CON_LSB 0
`endif

module tb_cpu_ex;
  logic                     clk, clr_n, in_valid, alu_src_imm, stall;
  logic [31:0]              current_pc, ins, reg_read1_data, reg_read2_data, imm_ext;
  logic [`CON_MSB:`CON_LSB] controls, ex_controls;
  logic [4:0]               alu_op;
  logic [31:0]              ex_current_pc, ex_ins, ex_reg_read2_data, ex_alu_result;
  int nvec = 0;
  int nerr = 0;

  cpu_ex dut (
    .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .current_pc(current_pc), .ins(ins),
    .controls(controls), .alu_op(alu_op), .reg_read1_data(reg_read1_data),
    .reg_read2_data(reg_read2_data), .imm_ext(imm_ext), .alu_src_imm(alu_src_imm),
    .stall(stall), .ex_current_pc(ex_current_pc), .ex_ins(ex_ins), .ex_controls(ex_controls),
    .ex_reg_read2_data(ex_reg_read2_data), .ex_alu_result(ex_alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] pc, input logic [`CON_MSB:`CON_LSB] ctrl);
    in_valid       = v;
    alu_op         = op;
    reg_read1_data = a;
    reg_read2_data = b;
    imm_ext        = 32'h0000_0000;
    alu_src_imm    = 1'b0;
    ins            = {16'hABCD, 5'd0, sh, 6'h00};
    current_pc     = pc;
    controls       = ctrl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    drive(1'b1, 5'd12, 32'h5, 32'h3, 5'd0, 32'h100, 16'h1234);
    #1;
    nvec++;
    if (stall !== 1'b0) begin nerr++; $display("FAIL reset_stall got=%b want=0", stall); end
    tick();
    tick();
    nvec++;
    if (ex_alu_result !== 32'd0 || ex_controls !== '0 || ex_current_pc !== 32'd0 ||
        ex_ins !== 32'd0 || ex_reg_read2_data !== 32'd0) begin
      nerr++;
      $display("FAIL reset_outputs got res=%h ctl=%h pc=%h ins=%h rd2=%h want all 0",
               ex_alu_result, ex_controls, ex_current_pc, ex_ins, ex_reg_read2_data);
    end
    drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 32'h0, 16'h0);
    clr_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    logic [4:0]  t_op [15];
    logic [31:0] t_a [15], t_b [15], t_exp [15];
    logic [4:0]  t_sh [15];
    logic [31:0] pc, exp_ins;
    t_op = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd8, 5'd20};
    t_a  = '{32'h7FFFFFFF, 32'h5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
             32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1};
    t_b  = '{32'h1, 32'h7, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00,
             32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h80000000, 32'h80000000, 32'h3, 32'h1};
    t_sh = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd4, 5'd4, 5'd31, 5'd0};
    t_exp = '{32'h80000000, 32'hFFFFFFFE, 32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'h000F000F,
              32'h1, 32'h0, 32'h0, 32'h1, 32'h10, 32'h08000000, 32'hF8000000, 32'h80000000, 32'h0};
    for (int i = 0; i < 15; i++) begin
      pc = 32'h0040_0000 + 32'(i * 4);
      exp_ins = {16'hABCD, 5'd0, t_sh[i], 6'h00};
      drive(1'b1, t_op[i], t_a[i], t_b[i], t_sh[i], pc, 16'h0100 + 16'(i));
      tick();
      nvec++;
      if (ex_alu_result !== t_exp[i]) begin
        nerr++;
        $display("FAIL alu[%0d] op=%0d got=%h want=%h", i, t_op[i], ex_alu_result, t_exp[i]);
      end
      nvec++;
      if (ex_controls !== 16'h0100 + 16'(i) || ex_current_pc !== pc || ex_ins !== exp_ins ||
          ex_reg_read2_data !== t_b[i]) begin
        nerr++;
        $display("FAIL alu_pass[%0d] got ctl=%h pc=%h ins=%h rd2=%h want ctl=%h pc=%h ins=%h rd2=%h",
                 i, ex_controls, ex_current_pc, ex_ins, ex_reg_read2_data,
                 16'h0100 + 16'(i), pc, exp_ins, t_b[i]);
      end
    end
  endtask

  task automatic test_imm();
    drive(1'b1, 5'd0, 32'd10, 32'h0000DEAD, 5'd0, 32'h200, 16'h0011);
    alu_src_imm = 1'b1;
    imm_ext = 32'd5;
    tick();
    nvec++;
    if (ex_alu_result !== 32'd15 || ex_reg_read2_data !== 32'h0000DEAD) begin
      nerr++;
      $display("FAIL imm_add got res=%h rd2=%h want res=0000000f rd2=0000dead", ex_alu_result, ex_reg_read2_data);
    end
    drive(1'b1, 5'd11, 32'd0, 32'h0000BEEF, 5'd0, 32'h204, 16'h0012);
    alu_src_imm = 1'b1;
    imm_ext = 32'h0000_1234;
    tick();
    nvec++;
    if (ex_alu_result !== 32'h12340000) begin
      nerr++;
      $display("FAIL lui got=%h want=12340000", ex_alu_result);
    end
  endtask

  task automatic test_bubble();
    drive(1'b0, 5'd0, 32'h1, 32'h2, 5'd3, 32'h300, 16'hFFFF);
    tick();
    nvec++;
    if (ex_alu_result !== 32'd0 || ex_controls !== '0 || ex_current_pc !== 32'd0 ||
        ex_ins !== 32'd0 || ex_reg_read2_data !== 32'd0) begin
      nerr++;
      $display("FAIL bubble got res=%h ctl=%h pc=%h ins=%h rd2=%h want all 0",
               ex_alu_result, ex_controls, ex_current_pc, ex_ins, ex_reg_read2_data);
    end
  endtask

  // Issue one mul/div op, count stall cycles, then read HI and LO back through MFHI/MFLO.
  task automatic test_muldiv(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    int want_n;
    logic [31:0] w_hi, w_lo;
    logic bubble_bad;
`ifdef CPU_EX_MULDIV_EN
    want_n = 33; w_hi = exp_hi; w_lo = exp_lo;
`else
    want_n = 0; w_hi = 32'd0; w_lo = 32'd0;
`endif
    drive(1'b1, op, a, b, 5'd0, 32'h400, 16'hA5A5);
    n = 0;
    bubble_bad = 1'b0;
    while (stall === 1'b1 && n < 60) begin
      n++;
      tick();
      if (ex_controls !== '0) bubble_bad = 1'b1;
    end
    nvec++;
    if (n != want_n) begin nerr++; $display("FAIL muldiv_stall op=%0d got=%0d cycles want=%0d", op, n, want_n); end
    nvec++;
    if (bubble_bad) begin nerr++; $display("FAIL muldiv_bubble op=%0d got nonzero ex_controls want 0", op); end
    tick();
    nvec++;
    if (ex_alu_result !== 32'd0 || ex_controls !== 16'hA5A5) begin
      nerr++;
      $display("FAIL muldiv_retire op=%0d got res=%h ctl=%h want res=0 ctl=a5a5", op, ex_alu_result, ex_controls);
    end
    drive(1'b1, 5'd16, 32'h0, 32'h0, 5'd0, 32'h404, 16'h0016);
    tick();
    nvec++;
    if (ex_alu_result !== w_hi || ex_controls !== 16'h0016) begin
      nerr++;
      $display("FAIL mfhi op=%0d got=%h ctl=%h want=%h ctl=0016", op, ex_alu_result, ex_controls, w_hi);
    end
    drive(1'b1, 5'd17, 32'h0, 32'h0, 5'd0, 32'h408, 16'h0017);
    tick();
    nvec++;
    if (ex_alu_result !== w_lo) begin
      nerr++;
      $display("FAIL mflo op=%0d got=%h want=%h", op, ex_alu_result, w_lo);
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] w_hi, w_lo;
`ifdef CPU_EX_MULDIV_EN
    w_hi = 32'h12345678; w_lo = 32'h9ABCDEF0;
`else
    w_hi = 32'd0; w_lo = 32'd0;
`endif
    drive(1'b1, 5'd18, 32'h12345678, 32'h0, 5'd0, 32'h500, 16'h0018);
    #1;
    nvec++;
    if (stall !== 1'b0) begin nerr++; $display("FAIL mthi_stall got=%b want=0", stall); end
    tick();
    nvec++;
    if (ex_alu_result !== 32'd0) begin nerr++; $display("FAIL mthi_result got=%h want=0", ex_alu_result); end
    drive(1'b1, 5'd19, 32'h9ABCDEF0, 32'h0, 5'd0, 32'h504, 16'h0019);
    tick();
    drive(1'b1, 5'd16, 32'h0, 32'h0, 5'd0, 32'h508, 16'h0016);
    tick();
    nvec++;
    if (ex_alu_result !== w_hi) begin nerr++; $display("FAIL mthi_read got=%h want=%h", ex_alu_result, w_hi); end
    drive(1'b1, 5'd17, 32'h0, 32'h0, 5'd0, 32'h50C, 16'h0017);
    tick();
    nvec++;
    if (ex_alu_result !== w_lo) begin nerr++; $display("FAIL mtlo_read got=%h want=%h", ex_alu_result, w_lo); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd13, 32'h3, 32'h5, 5'd0, 32'h600, 16'h00C0);
    for (int i = 0; i < 60 && stall === 1'b1; i++) tick();
    tick();
    drive(1'b1, 5'd0, 32'h0000_0100, 32'h0000_0023, 5'd0, 32'h604, 16'h00C1);
    #1;
    nvec++;
    if (stall !== 1'b0) begin nerr++; $display("FAIL b2b_stall got=%b want=0", stall); end
    tick();
    nvec++;
    if (ex_alu_result !== 32'h0000_0123 || ex_current_pc !== 32'h604) begin
      nerr++;
      $display("FAIL b2b_add got res=%h pc=%h want res=00000123 pc=00000604", ex_alu_result, ex_current_pc);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd15, 32'h7, 32'h0, 5'd0, 32'h700, 16'h00D0);
    for (int i = 0; i < 9; i++) tick();
    clr_n = 1'b0;
    tick();
    nvec++;
    if (stall !== 1'b0 || ex_alu_result !== 32'd0 || ex_controls !== '0 || ex_current_pc !== 32'd0) begin
      nerr++;
      $display("FAIL reset_mid got stall=%b res=%h ctl=%h pc=%h want all 0", stall, ex_alu_result, ex_controls, ex_current_pc);
    end
    drive(1'b1, 5'd17, 32'h0, 32'h0, 5'd0, 32'h704, 16'h00D1);
    clr_n = 1'b1;
    #1;
    nvec++;
    if (stall !== 1'b0) begin nerr++; $display("FAIL reset_mid_idle got stall=%b want=0", stall); end
    tick();
    nvec++;
    if (ex_alu_result !== 32'd0 || ex_controls !== 16'h00D1) begin
      nerr++;
      $display("FAIL reset_mid_mflo got res=%h ctl=%h want res=0 ctl=00d1", ex_alu_result, ex_controls);
    end
  endtask

  initial begin
    clr_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 32'h0, 16'h0);
    test_reset();
    test_alu();
    test_imm();
    test_bubble();
    test_muldiv(5'd12, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE);
    test_muldiv(5'd13, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE);
    test_muldiv(5'd14, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    test_muldiv(5'd14, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    test_muldiv(5'd15, 32'h7, 32'h0, 32'h00000007, 32'hFFFFFFFF);
    test_muldiv(5'd14, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    test_mthi_mtlo();
    test_back_to_back();
    test_muldiv(5'd15, 32'h7, 32'h0, 32'h00000007, 32'hFFFFFFFF);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/cpu_ex.md
# cpu_ex

Execute stage of the five-stage MIPS pipeline, sitting between the decode stage and `cpu_mem`. It computes the ALU result for single-cycle operations. An iterative 32-cycle multiply/divide unit owns the HI/LO registers. Results, instruction and controls are registered into the EX/MEM pipeline register that `cpu_mem` consumes. While a multiply or divide is in progress, the stage stalls the front end and issues bubbles downstream.

## Interface
- No parameters; widths fixed by `defines.vh`.
- `clk`  in  1  global clock; all state updates on rising edge.
- `clr_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  ID holds a valid instruction; low means bubble.
- `current_pc`  in  32  PC of the instruction in EX.
- `ins`  in  32  raw instruction; `ins[10:6]` is the shift amount.
- `controls`  in  `CON_MSB:CON_LSB`  control bundle from ID; all-zero is the NOP encoding.
- `alu_op`  in  5  operation code, listed below.
- `reg_read1_data`  in  32  operand A (rs).
- `reg_read2_data`  in  32  rs2 data (rt), also forwarded for stores.
- `imm_ext`  in  32  extended immediate.
- `alu_src_imm`  in  1  operand B is `imm_ext` when 1, else `reg_read2_data`.
- `stall`  out  1  combinational; front end must hold PC and the ID/EX inputs steady while high.
- `ex_current_pc`  out  32  registered, to MEM `current_pc`.
- `ex_ins`  out  32  registered, to MEM `ins`.
- `ex_controls`  out  `CON_MSB:CON_LSB`  registered, to MEM `controls`.
- `ex_reg_read2_data`  out  32  registered, to MEM `reg_read2_data`.
- `ex_alu_result`  out  32  registered, to MEM `alu_result`.

## Operation
- `alu_op` encoding:
  - Arithmetic and logic: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU.
  - Shifts: 8 SLL, 9 SRL, 10 SRA, each shifting B by `ins[10:6]`. 11 LUI gives `{B[15:0],16'h0}`.
  - Multiply/divide: 12 MULT, 13 MULTU, 14 DIV, 15 DIVU.
  - HI/LO moves: 16 MFHI, 17 MFLO, 18 MTHI (HI←A), 19 MTLO (LO←A).
  - Other codes give result 0.
- ADD/SUB wrap modulo 2^32 with no overflow trap. SLT/SLTU produce 0 or 1.
- Multiply/divide FSM states:
  - IDLE to BUSY: `in_valid` and op 12–15. Latch the operand magnitudes and the signedness, and clear `cnt`.
  - BUSY: one shift-add (multiply) or restoring-subtract (divide) step per cycle; `cnt` runs 0..31.
  - BUSY to DONE: at `cnt==31`. On that edge HI/LO are written and their signs are corrected.
  - DONE to IDLE: unconditional. The mul/div instruction retires into EX/MEM with `ex_alu_result`=0, and is not restarted even though it is still on the inputs.
- Multiply results: HI = product[63:32], LO = product[31:0].
- Divide results: LO = quotient, HI = remainder. Signed quotient sign is `A^B`; remainder sign follows the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divisor 0, either signedness, gives HI=A and LO=0xFFFFFFFF; all 32 cycles still elapse.
- `stall` = (IDLE and `in_valid` and op 12–15) or BUSY.
- EX/MEM register:
  - When `stall` is high or `in_valid` is low, it loads a bubble: all outputs 0.
  - Otherwise it loads the inputs and the computed result.
- MTHI/MTLO write on the edge where the instruction is not stalled.
- MFHI/MFLO read the current HI/LO register; there is no internal bypass.

## Timing
- Reset (`clr_n`=0 at an edge): all `ex_*` outputs 0, HI=LO=0, FSM IDLE, `cnt`=0. `stall` is forced to 0 while `clr_n` is low.
- Reset mid-operation: the operation is abandoned and HI/LO are cleared.
- Single-cycle ops: 1-cycle latency, input at edge N appears on `ex_*` after edge N.
- Mul/div presented in cycle T0:
  - `stall` is high T0..T32 (33 cycles), with bubbles to MEM.
  - FSM is in DONE in T33; `stall` is low and the instruction enters EX/MEM at the end of T33.
  - HI/LO are valid from T33.
- MFHI/MFLO presented in T34 reads the new values.
- The front end must not change the ID/EX inputs while `stall` is high; behaviour is undefined otherwise.

## Configuration
- `CPU_EX_MULDIV_EN` defined: FSM, HI/LO and ops 12–19 are implemented as above.
- `CPU_EX_MULDIV_EN` undefined:
  - No FSM or HI/LO; `stall` is tied to 0.
  - Ops 12–15 and 18–19 pass through in 1 cycle as no-ops with result 0.
  - MFHI/MFLO return 0.

## Test plan
- ADD A=0x7FFFFFFF, B=1 → `ex_alu_result`=0x80000000 after 1 edge. SLT A=0xFFFFFFFF, B=0 → 1. SLTU with the same operands → 0.
- MULT A=0xFFFFFFFF, B=2 → `stall` high exactly 33 cycles, then MFHI=0xFFFFFFFF, MFLO=0xFFFFFFFE. MULTU with the same operands → HI=1, LO=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU A=7, B=0 → HI=7, LO=0xFFFFFFFF after the full 33-cycle stall.
- Start DIVU, assert `clr_n`=0 in stall cycle 10 → next cycle `stall`=0 and all outputs 0. A following MFLO returns 0.
- `stall` cycles → `ex_controls`=0 each cycle. The first instruction after DONE (e.g. ADD) is registered in the cycle after DONE with its correct result.
